apb_slave_regs: RTL and testbench

APB_SLAVE_REGS -- requirements
Module: apb_slave_regs

---
 rtl/apb_slave_regs.sv | 130 +++++++++++++
 tb/tb_apb_slave_regs.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regs.sv
// APB slave with a small register file: ID, CTRL (wait-state count), two scratch
// registers, a W1C status register and a write counter.
module apb_slave_regs #(
    parameter logic [31:0] ID_VALUE = 32'hA0B0_0001
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

    localparam logic [31:0] ADDR_ID      = 32'h00;
    localparam logic [31:0] ADDR_CTRL    = 32'h04;
    localparam logic [31:0] ADDR_SCRATCH0 = 32'h08;
    localparam logic [31:0] ADDR_SCRATCH1 = 32'h0C;
    localparam logic [31:0] ADDR_STATUS  = 32'h10;
    localparam logic [31:0] ADDR_WCOUNT  = 32'h14;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [3:0]  ctrl_wait;
    logic [31:0] scratch0;
    logic [31:0] scratch1;
    logic [1:0]  status;      // [0] ERR_SEEN, [1] WR_SEEN
    logic [31:0] wcount;

    logic        addr_invalid;
    logic        complete;
    logic        wr_ok;
    logic [31:0] rd_value;

    always_comb begin
        addr_invalid = (PADDR[1:0] != 2'b00) || (PADDR > ADDR_WCOUNT) ||
                       (PWRITE && ((PADDR == ADDR_ID) || (PADDR == ADDR_WCOUNT)));
        PREADY   = (state == ACCESS) && PENABLE && (cnt == 4'd0);
        PSLVERR  = PREADY && addr_invalid;
        complete = PREADY && PSEL;
        wr_ok    = complete && PWRITE && !addr_invalid;
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and a latch is never inferred.
    always_comb begin
        rd_value = 32'd0;
        case (PADDR)
            ADDR_ID:       rd_value = ID_VALUE;
            ADDR_CTRL:     rd_value = {28'd0, ctrl_wait};
            ADDR_SCRATCH0: rd_value = scratch0;
            ADDR_SCRATCH1: rd_value = scratch1;
            ADDR_STATUS:   rd_value = {30'd0, status};
            ADDR_WCOUNT:   rd_value = wcount;
            default:       rd_value = 32'd0;
        endcase
        PRDATA = (PREADY && !PWRITE && !addr_invalid) ? rd_value : 32'd0;
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                // PENABLE high while idle is a protocol violation and is ignored.
                if (PSEL && !PENABLE) begin
                    state_next = ACCESS;
                    cnt_next   = ctrl_wait;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_next = IDLE;
                end else if (PREADY) begin
                    state_next = IDLE;
                end else if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ctrl_wait <= 4'd0;
            scratch0  <= 32'd0;
            scratch1  <= 32'd0;
            status    <= 2'b00;
            wcount    <= 32'd0;
        end else begin
            if (complete && addr_invalid) begin
                status[0] <= 1'b1;
            end
            if (wr_ok) begin
                wcount    <= wcount + 32'd1;
                status[1] <= 1'b1;
                case (PADDR)
                    ADDR_CTRL:     ctrl_wait <= PWDATA[3:0];
                    ADDR_SCRATCH0: scratch0  <= PWDATA;
                    ADDR_SCRATCH1: scratch1  <= PWDATA;
                    // W1C, with this write's own WR_SEEN set taking priority.
                    ADDR_STATUS:   status    <= (status & ~PWDATA[1:0]) | 2'b10;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed self-checking bench for apb_slave_regs: ID read, wait states, errors,
// W1C, abort, protocol violation, reset mid-transfer and WCOUNT wrap.
module tb_apb_slave_regs;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int checks = 0;
    int errors = 0;

    apb_slave_regs dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Setup edge, then raise PENABLE; returns at the start of the first access cycle.
    task automatic start_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int waits);
        bit done = 1'b0;
        waits = 0; rdata = 32'd0; err = 1'b0;
        start_xfer(wr, addr, wdata);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge PCLK);
            if (PREADY) begin
                rdata = PRDATA; err = PSLVERR; done = 1'b1;
            end else begin
                waits++;
                @(posedge PCLK); #1;
            end
        end
        if (!done) check("pready_timeout", 32'd0, 32'd1);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic exp_err, input int exp_waits);
        logic [31:0] rd; logic err; int waits;
        xfer(1'b1, addr, data, rd, err, waits);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_waits"}, waits, exp_waits);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic exp_err, input int exp_waits);
        logic [31:0] rd; logic err; int waits;
        xfer(1'b0, addr, 32'd0, rd, err, waits);
        check({tag, "_data"}, rd, exp_data);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_waits"}, waits, exp_waits);
    endtask

    initial begin
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 32'd0; PWDATA = 32'd0;
        #12;
        check("rst_pready", 32'(PREADY), 32'd0);
        check("rst_pslverr", 32'(PSLVERR), 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;

        // Zero-wait ID read.
        do_read("id", 32'h00, 32'hA0B0_0001, 1'b0, 0);

        // Wait states: CTRL=3 applies from the following transfer.
        do_write("ctrl3", 32'h04, 32'd3, 1'b0, 0);
        do_write("s0", 32'h08, 32'hDEAD_BEEF, 1'b0, 3);
        do_read("s0_rd", 32'h08, 32'hDEAD_BEEF, 1'b0, 3);
        do_read("wcount2", 32'h14, 32'd2, 1'b0, 3);
        do_read("ctrl_rd", 32'h04, 32'd3, 1'b0, 3);
        do_read("status_wr", 32'h10, 32'h2, 1'b0, 3);
        do_write("ctrl0", 32'h04, 32'd0, 1'b0, 3);

        // Errors and W1C.
        do_write("wr_wcount", 32'h14, 32'h1234, 1'b1, 0);
        do_read("wcount3", 32'h14, 32'd3, 1'b0, 0);
        do_read("status_err", 32'h10, 32'h3, 1'b0, 0);
        do_read("rd_0x18", 32'h18, 32'd0, 1'b1, 0);
        do_read("rd_misalign", 32'h06, 32'd0, 1'b1, 0);
        do_write("wr_id", 32'h00, 32'hFFFF_FFFF, 1'b1, 0);
        do_read("id_kept", 32'h00, 32'hA0B0_0001, 1'b0, 0);
        do_write("w1c_err", 32'h10, 32'h1, 1'b0, 0);
        do_read("status_w1c", 32'h10, 32'h2, 1'b0, 0);
        do_write("w1c_both", 32'h10, 32'h3, 1'b0, 0);
        do_read("status_setwins", 32'h10, 32'h2, 1'b0, 0);
        do_write("ctrl_hi", 32'h04, 32'hFFFF_FFF0, 1'b0, 0);
        do_read("ctrl_mask", 32'h04, 32'd0, 1'b0, 0);
        do_read("wcount6", 32'h14, 32'd6, 1'b0, 0);

        // Abort a SCRATCH1 write after two access cycles with WAIT=5.
        do_write("ctrl5", 32'h04, 32'd5, 1'b0, 0);
        start_xfer(1'b1, 32'h0C, 32'hCAFE_F00D);
        @(negedge PCLK);
        check("abort_acc1_pready", 32'(PREADY), 32'd0);
        @(posedge PCLK); #1;
        @(negedge PCLK);
        check("abort_acc2_pready", 32'(PREADY), 32'd0);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        check("abort_state", 32'(dut.state), 32'd0);

        // PENABLE without setup while idle is ignored.
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 32'h00;
        @(negedge PCLK);
        check("viol_pready", 32'(PREADY), 32'd0);
        @(posedge PCLK); #1;
        check("viol_state", 32'(dut.state), 32'd0);
        check("viol_pready2", 32'(PREADY), 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;

        do_read("s1_unchanged", 32'h0C, 32'd0, 1'b0, 5);
        do_read("wcount7", 32'h14, 32'd7, 1'b0, 5);

        // Reset asserted during a wait state.
        start_xfer(1'b1, 32'h08, 32'h0000_0055);
        @(negedge PCLK);
        PRESET = 1'b1;
        #1;
        check("midrst_pready", 32'(PREADY), 32'd0);
        check("midrst_state", 32'(dut.state), 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        do_read("post_id", 32'h00, 32'hA0B0_0001, 1'b0, 0);
        do_read("post_ctrl", 32'h04, 32'd0, 1'b0, 0);
        do_read("post_s0", 32'h08, 32'd0, 1'b0, 0);
        do_read("post_s1", 32'h0C, 32'd0, 1'b0, 0);
        do_read("post_status", 32'h10, 32'd0, 1'b0, 0);
        do_read("post_wcount", 32'h14, 32'd0, 1'b0, 0);

        // WCOUNT wrap from 0xFFFFFFFF.
        @(negedge PCLK);
        force dut.wcount = 32'hFFFF_FFFF;
        @(posedge PCLK); #1;
        release dut.wcount;
        do_read("wcount_max", 32'h14, 32'hFFFF_FFFF, 1'b0, 0);
        do_write("s1_wrap", 32'h0C, 32'h0000_0001, 1'b0, 0);
        do_read("wcount_wrap", 32'h14, 32'd0, 1'b0, 0);
        do_read("s1_rd", 32'h0C, 32'h0000_0001, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
